sifh_peak_reader: RTL

// Readout side of the SiFH histogram RAM. After the acquisition FSM has accumulated
// per-pixel TDC histograms through RAM port A, this block scans port B pixel by pixel.
// For each histogram it finds the bin with the largest count. It hands (pixel, bin,

---
 rtl/sifh_peak_reader_if.sv | 38 +++
 rtl/sifh_peak_reader.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/sifh_peak_reader_if.sv
`default_nettype none
// ============================================================================
// Interface : sifh_peak_reader_if
// Brief     : Control, histogram-RAM port B and peak-result handshake bundle.
// Revision  : 1.0
// ============================================================================
interface sifh_peak_reader_if #(
    parameter int NB       = 6,
    parameter int PIX_W    = 2,
    parameter int CNT_W    = 8,
    parameter int RAM_ADDR = NB + PIX_W
) ();
    logic                start;
    logic                busy;
    logic                done;
    logic [RAM_ADDR-1:0] raddr;
    logic                rEnable;
    logic                readFlag;
    logic [CNT_W-1:0]    counts;
    logic                peakValid;
    logic                peakReady;
    logic [PIX_W-1:0]    peakPixel;
    logic [NB-1:0]       peakBin;
    logic [CNT_W-1:0]    peakCount;

    modport master (
        input  start, counts, peakReady,
        output busy, done, raddr, rEnable, readFlag,
        output peakValid, peakPixel, peakBin, peakCount
    );

    modport slave (
        output start, counts, peakReady,
        input  busy, done, raddr, rEnable, readFlag,
        input  peakValid, peakPixel, peakBin, peakCount
    );
endinterface
`default_nettype wire

// File: rtl/sifh_peak_reader.sv
`default_nettype none
// ============================================================================
// Module   : sifh_peak_reader
// Brief    : Scans histogram RAM port B pixel by pixel and emits the peak
//            (pixel, bin, count) of each histogram over valid/ready.
// Revision : 1.0
// ============================================================================
module sifh_peak_reader #(
    parameter int BIN_NUM   = 64,
    parameter int PIXEL_NUM = 4,
    parameter int NB        = 6,
    parameter int PIX_W     = 2,
    parameter int RAM_ADDR  = 8,
    parameter int CNT_W     = 8,
    parameter int RD_LAT    = 1
) (
    input  logic               clk,
    input  logic               res,
    sifh_peak_reader_if.master bus
);
    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SCAN  = 3'd1;
    localparam logic [2:0] c_DRAIN = 3'd2;
    localparam logic [2:0] c_EMIT  = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    localparam logic [NB-1:0]    c_LAST_BIN = NB'(BIN_NUM - 1);
    localparam logic [PIX_W-1:0] c_LAST_PIX = PIX_W'(PIXEL_NUM - 1);

    logic [2:0]              r_state;
    logic [2:0]              w_next;
    logic [PIX_W-1:0]        r_pixel;
    logic [NB-1:0]           r_bin;
    logic [RAM_ADDR-1:0]     r_raddr_last;
    logic [RD_LAT-1:0]       r_pv;
    logic [RD_LAT-1:0][NB-1:0] r_pb;
    logic [CNT_W-1:0]        r_max_cnt;
    logic [NB-1:0]           r_max_bin;

    logic w_busy;
    logic w_done;
    logic w_rd;
    logic w_valid;
    logic w_last_bin;
    logic w_last_pix;
    logic w_ret_vld;
    logic [NB-1:0] w_ret_bin;
    logic w_accept;
    logic w_start_ok;

    assign w_last_bin = (r_bin == c_LAST_BIN);
    assign w_last_pix = (r_pixel == c_LAST_PIX);
    assign w_ret_vld  = r_pv[RD_LAT-1];
    assign w_ret_bin  = r_pb[RD_LAT-1];
    assign w_accept   = w_valid && bus.peakReady;
    assign w_start_ok = (r_state == c_IDLE) && bus.start;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (bus.start) w_next = c_SCAN;
            c_SCAN:  if (w_last_bin) w_next = c_DRAIN;
            c_DRAIN: if (w_ret_vld && (w_ret_bin == c_LAST_BIN)) w_next = c_EMIT;
            c_EMIT:  if (bus.peakReady) w_next = w_last_pix ? c_DONE : c_SCAN;
            c_DONE:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_rd    = 1'b0;
        w_valid = 1'b0;
        case (r_state)
            c_SCAN:  begin w_busy = 1'b1; w_rd = 1'b1;    end
            c_DRAIN: begin w_busy = 1'b1;                 end
            c_EMIT:  begin w_busy = 1'b1; w_valid = 1'b1; end
            c_DONE:  begin w_done = 1'b1;                 end
            default: ;
        endcase
    end

    // Address counters; the bin counter wraps to 0 after the last bin of a pixel.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_pixel      <= '0;
            r_bin        <= '0;
            r_raddr_last <= '0;
        end else begin
            if (w_start_ok) begin
                r_pixel <= '0;
                r_bin   <= '0;
            end
            if (w_rd) begin
                r_bin        <= r_bin + NB'(1);
                r_raddr_last <= {r_pixel, r_bin};
            end
            if (w_accept && !w_last_pix) begin
                r_pixel <= r_pixel + PIX_W'(1);
            end
        end
    end

    // Return pipeline tags each read so the compare knows which bin arrived.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_pv <= '0;
            r_pb <= '0;
        end else begin
            r_pv[0] <= w_rd;
            r_pb[0] <= r_bin;
            for (int k = 1; k < RD_LAT; k++) begin
                r_pv[k] <= r_pv[k-1];
                r_pb[k] <= r_pb[k-1];
            end
        end
    end

    // Bin 0 always loads; later bins need a strictly larger count so ties keep the lowest bin.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_max_cnt <= '0;
            r_max_bin <= '0;
        end else if (w_accept || w_start_ok) begin
            r_max_cnt <= '0;
            r_max_bin <= '0;
        end else if (w_ret_vld && ((w_ret_bin == '0) || (bus.counts > r_max_cnt))) begin
            r_max_cnt <= bus.counts;
            r_max_bin <= w_ret_bin;
        end
    end

    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.rEnable   = w_rd;
    assign bus.readFlag  = w_rd;
    assign bus.raddr     = w_rd ? {r_pixel, r_bin} : r_raddr_last;
    assign bus.peakValid = w_valid;
    assign bus.peakPixel = r_pixel;
    assign bus.peakBin   = r_max_bin;
    assign bus.peakCount = r_max_cnt;

endmodule
`default_nettype wire
